// File: rtl/fc_vec_stream_tx.sv
// Ping-pong vector buffer: a writer fills one N x T bank by address and commits it,
// while the other bank streams out element by element over a valid/ready handshake.

module fc_vec_stream_bank #(
  parameter int T = 16,
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [T-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [T-1:0]  rdata
);
  // Payload storage is deliberately left unreset; only the control state is cleared.
  logic [N-1:0][T-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

module fc_vec_stream_tx #(
  parameter int T = 16,
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [T-1:0]  wr_data,
  input  logic          wr_commit,
  output logic          wr_ready,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [T-1:0]  output_data,
  output logic          vec_done
);
  logic [1:0]          full_q, full_d;
  logic                wbank_q, wbank_d;
  logic                rbank_q, rbank_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                vec_done_q, vec_done_d;
  logic [1:0][T-1:0]   bank_rdata;
  logic                hs, last, addr_ok, wr_fire, commit;

  always_comb begin
    wr_ready     = !full_q[wbank_q];
    output_valid = full_q[rbank_q];
    hs           = output_valid && output_ready;
    last         = (idx_q == AW'(N - 1));
    addr_ok      = ({1'b0, wr_addr} < (AW + 1)'(N));
    wr_fire      = wr_ready && wr_en && addr_ok;
    commit       = wr_ready && wr_commit;
    output_data  = output_valid ? bank_rdata[rbank_q] : '0;
    vec_done     = vec_done_q;
  end

  // A commit needs an empty write bank and a release needs a full read bank,
  // so when both fire in one cycle they always touch different banks.
  always_comb begin
    full_d     = full_q;
    wbank_d    = wbank_q;
    rbank_d    = rbank_q;
    idx_d      = idx_q;
    vec_done_d = 1'b0;
    if (commit) begin
      full_d[wbank_q] = 1'b1;
      wbank_d         = !wbank_q;
    end
    if (hs) begin
      if (last) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
        idx_d           = '0;
        vec_done_d      = 1'b1;
      end else begin
        idx_d = idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      idx_q      <= '0;
      vec_done_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      idx_q      <= idx_d;
      vec_done_q <= vec_done_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fc_vec_stream_bank #(.T(T), .N(N)) u_bank (
      .clk   (clk),
      .we    (wr_fire && (wbank_q == 1'(b))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (idx_q),
      .rdata (bank_rdata[b])
    );
  end
endmodule

// File: tb/tb_fc_vec_stream_tx.sv
// Bench for fc_vec_stream_tx: directed scenarios plus random traffic, every cycle
// compared against a queue-of-vectors reference model.

module tb_fc_vec_stream_tx;
  localparam int T  = 16;
  localparam int N  = 8;
  localparam int AW = $clog2(N);

  typedef logic [N-1:0][T-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, wr_commit, output_ready;
  logic [AW-1:0] wr_addr;
  logic [T-1:0]  wr_data;
  logic          wr_ready, output_valid, vec_done;
  logic [T-1:0]  output_data;

  always #5 clk = ~clk;

  fc_vec_stream_tx #(.T(T), .N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_commit    (wr_commit),
    .wr_ready     (wr_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data),
    .vec_done     (vec_done)
  );

  // Model: committed vectors waiting to stream, oldest first; at most two.
  vec_t pend[$];
  vec_t fill;
  int   rd_pos;
  bit   done_m;
  int   n_chk, n_pass;
  int   wr_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    bit v, wok, hs, dn;
    @(negedge clk);
    v   = pend.size() > 0;
    wok = pend.size() < 2;
    chk("output_valid", 32'(output_valid), 32'(v));
    chk("output_data", 32'(output_data), v ? 32'(pend[0][rd_pos]) : 32'd0);
    chk("wr_ready", 32'(wr_ready), 32'(wok));
    chk("vec_done", 32'(vec_done), 32'(done_m));
    hs = v && output_ready;
    dn = 1'b0;
    if (wok && wr_en && int'(wr_addr) < N) fill[wr_addr] = wr_data;
    if (hs) begin
      rd_pos++;
      if (rd_pos == N) begin
        void'(pend.pop_front());
        rd_pos = 0;
        dn     = 1'b1;
      end
    end
    if (wok && wr_commit) pend.push_back(fill);
    done_m = dn;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input int addr, input int data, input bit cm, input bit rdy);
    wr_en        = en;
    wr_addr      = AW'(addr);
    wr_data      = T'(data);
    wr_commit    = cm;
    output_ready = rdy;
    step();
  endtask

  task automatic write_vec(input int base, input bit commit_last, input bit rdy);
    for (int i = 0; i < N; i++)
      drive(1'b1, i, base + i, commit_last && (i == N - 1), rdy);
    if (!commit_last) drive(1'b0, 0, 0, 1'b1, rdy);
  endtask

  task automatic idle(input int cycles, input bit rdy);
    for (int i = 0; i < cycles; i++) drive(1'b0, 0, 0, 1'b0, rdy);
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_output_valid", 32'(output_valid), 32'd0);
    chk("rst_output_data", 32'(output_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_vec_done", 32'(vec_done), 32'd0);
    wr_en = 1'b0; wr_commit = 1'b0; output_ready = 1'b0; wr_addr = '0; wr_data = '0;
    pend.delete();
    rd_pos = 0;
    done_m = 1'b0;
    wr_e   = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; rd_pos = 0; done_m = 1'b0; wr_e = 0; fill = '0;
    reset = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; output_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single vector 1..N, separate commit, full-rate drain.
    for (int i = 0; i < N; i++) drive(1'b1, i, i + 1, 1'b0, 1'b0);
    drive(1'b0, 0, 0, 1'b1, 1'b1);
    idle(N + 3, 1'b1);

    // Last write lands in the same cycle as its commit.
    write_vec(16'h0A00, 1'b1, 1'b0);
    idle(N + 3, 1'b1);

    // Two vectors back to back, no bubble between them.
    write_vec(16'h0010, 1'b0, 1'b0);
    write_vec(16'hFFF0, 1'b0, 1'b0);
    drive(1'b1, 3, 16'hDEAD, 1'b1, 1'b0);
    idle(2 * N + 3, 1'b1);

    // Both banks full: commit collides with the last-element release and is dropped.
    write_vec(16'h1100, 1'b0, 1'b0);
    write_vec(16'h2200, 1'b0, 1'b0);
    idle(N - 1, 1'b1);
    drive(1'b1, 0, 16'hBEEF, 1'b1, 1'b1);
    idle(N + 3, 1'b1);

    // Reset after three accepted elements, then a fresh vector.
    write_vec(16'h3300, 1'b0, 1'b0);
    idle(3, 1'b1);
    do_reset();
    write_vec(16'h4400, 1'b0, 1'b0);
    idle(N + 3, 1'b1);

    // Random traffic: ready at 50%, writes with gaps, commits when or after complete.
    wr_e = 0;
    for (int c = 0; c < 1500; c++) begin
      bit rdy, en, cm;
      int addr, data;
      rdy = ($urandom_range(0, 1) == 1);
      en = 1'b0; cm = 1'b0; addr = 0; data = int'($urandom_range(0, 16'hFFFF));
      if (pend.size() < 2) begin
        if (wr_e < N && $urandom_range(0, 9) < 7) begin
          en = 1'b1; addr = wr_e;
          if (wr_e == N - 1 && $urandom_range(0, 1) == 1) begin
            cm = 1'b1; wr_e = 0;
          end else wr_e++;
        end else if (wr_e == N && $urandom_range(0, 9) < 6) begin
          cm = 1'b1; wr_e = 0;
        end
      end else begin
        en = ($urandom_range(0, 1) == 1);
        cm = ($urandom_range(0, 1) == 1);
        addr = int'($urandom_range(0, N - 1));
      end
      drive(en, addr, data, cm, rdy);
    end
    idle(3 * N, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
